// File: rtl/acc_window_if.sv
// acc_window_if: sample, accumulator and result-handshake signals of acc_window_ctrl
interface acc_window_if #(
   parameter int DIN_WIDTH = 16,
   parameter int ACC_WIDTH = 32,
   parameter int LEN_WIDTH = 16
);
   logic [LEN_WIDTH-1:0] acc_len;
   logic [DIN_WIDTH-1:0] din;
   logic                 din_valid;
   logic [DIN_WIDTH-1:0] acc_din;
   logic                 acc_din_valid;
   logic                 acc_done;
   logic [ACC_WIDTH-1:0] acc_dout;
   logic                 acc_dout_valid;
   logic [ACC_WIDTH-1:0] dout;
   logic                 dout_valid;
   logic                 dout_ready;
   logic                 overflow;
   logic [LEN_WIDTH-1:0] win_cnt;

   modport slave (
      input  acc_len, din, din_valid, acc_dout, acc_dout_valid, dout_ready,
      output acc_din, acc_din_valid, acc_done, dout, dout_valid, overflow, win_cnt
   );

   modport master (
      output acc_len, din, din_valid, acc_dout, acc_dout_valid, dout_ready,
      input  acc_din, acc_din_valid, acc_done, dout, dout_valid, overflow, win_cnt
   );
endinterface

// File: rtl/acc_window_ctrl.sv
// acc_window_ctrl: frames a sample stream into accumulator windows and
// buffers completed window sums in a 2-entry FIFO.
module acc_window_ctrl #(
   parameter int DIN_WIDTH = 16,
   parameter int ACC_WIDTH = 32,
   parameter int LEN_WIDTH = 16
) (
   input logic        clk,
   input logic        rst,
   acc_window_if.slave bus
);
   typedef enum logic {S_WAIT, S_RUN} state_t;
   state_t               r_state, w_state_n;
   logic [LEN_WIDTH-1:0] r_len, r_cnt, w_cnt_n, w_len_in;
   logic                 w_start;
   logic [DIN_WIDTH-1:0] r_acc_din;
   logic                 r_acc_din_valid, r_acc_done;
   logic [ACC_WIDTH-1:0] r_mem [2];
   logic                 r_rd, r_wr, r_primed, r_ovf;
   logic [1:0]           r_count;
   logic                 w_push, w_pop, w_accept;

   always_comb begin
      w_len_in  = (bus.acc_len == '0) ? LEN_WIDTH'(1) : bus.acc_len;
      w_start   = bus.din_valid && (r_state == S_WAIT || r_cnt == r_len);
      w_state_n = bus.din_valid ? S_RUN : r_state;
      w_cnt_n   = !bus.din_valid ? r_cnt : w_start ? LEN_WIDTH'(1) : r_cnt + LEN_WIDTH'(1);
      w_pop     = (r_count != 2'd0) && bus.dout_ready;
      w_push    = bus.acc_dout_valid && r_primed;
      w_accept  = w_push && (r_count != 2'd2 || w_pop);
   end

   // The first accumulator report after reset carries stale contents and is skipped.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_WAIT;
         r_len           <= '0;
         r_cnt           <= '0;
         r_acc_din       <= '0;
         r_acc_din_valid <= 1'b0;
         r_acc_done      <= 1'b0;
         r_mem[0]        <= '0;
         r_mem[1]        <= '0;
         r_rd            <= 1'b0;
         r_wr            <= 1'b0;
         r_count         <= 2'd0;
         r_primed        <= 1'b0;
         r_ovf           <= 1'b0;
      end else begin
         r_state         <= w_state_n;
         r_cnt           <= w_cnt_n;
         if (w_start) r_len <= w_len_in;
         r_acc_din       <= bus.din;
         r_acc_din_valid <= bus.din_valid;
         r_acc_done      <= w_start;
         if (bus.acc_dout_valid) r_primed <= 1'b1;
         if (w_accept) begin
            r_mem[r_wr] <= bus.acc_dout;
            r_wr        <= ~r_wr;
         end
         if (w_pop) r_rd <= ~r_rd;
         r_count <= r_count + {1'b0, w_accept} - {1'b0, w_pop};
         if (w_push && !w_accept) r_ovf <= 1'b1;
      end
   end

   assign bus.acc_din       = r_acc_din;
   assign bus.acc_din_valid = r_acc_din_valid;
   assign bus.acc_done      = r_acc_done;
   assign bus.dout          = r_mem[r_rd];
   assign bus.dout_valid    = (r_count != 2'd0);
   assign bus.overflow      = r_ovf;
   assign bus.win_cnt       = r_cnt;
endmodule

// File: tb/tb_acc_window_ctrl.sv
// tb_acc_window_ctrl: directed bench with a behavioural accumulator model
// and a capture queue of every accepted dout.
module tb_acc_window_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   acc_window_if #(.DIN_WIDTH(16), .ACC_WIDTH(32), .LEN_WIDTH(16)) bus ();
   acc_window_ctrl #(.DIN_WIDTH(16), .ACC_WIDTH(32), .LEN_WIDTH(16)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] q [$];
   logic [31:0] acc_sum = '0;

   // Accumulator: marker loads and reports the previous sum one cycle later.
   always @(posedge clk) begin
      bus.acc_dout_valid <= bus.acc_din_valid && bus.acc_done;
      if (bus.acc_din_valid && bus.acc_done) begin
         bus.acc_dout <= acc_sum;
         acc_sum      <= {16'd0, bus.acc_din};
      end else if (bus.acc_din_valid)
         acc_sum <= acc_sum + {16'd0, bus.acc_din};
      if (bus.dout_valid && bus.dout_ready) q.push_back(bus.dout);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [15:0] d);
      bus.din_valid = v;
      bus.din       = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 16'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      q.delete();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_acc_din"}, 64'(bus.acc_din), 0);
      chk({tag, "_acc_din_valid"}, 64'(bus.acc_din_valid), 0);
      chk({tag, "_acc_done"}, 64'(bus.acc_done), 0);
      chk({tag, "_win_cnt"}, 64'(bus.win_cnt), 0);
      chk({tag, "_dout"}, 64'(bus.dout), 0);
      chk({tag, "_dout_valid"}, 64'(bus.dout_valid), 0);
      chk({tag, "_overflow"}, 64'(bus.overflow), 0);
   endtask

   initial begin
      bus.acc_len    = 16'd4;
      bus.dout_ready = 1'b1;
      bus.din        = 16'd0;
      bus.din_valid  = 1'b0;
      idle(3);
      chk_reset("rst0");
      rst = 1'b0;
      q.delete();

      // len 4, samples 1..12 back to back
      for (int i = 1; i <= 12; i++) begin
         step(1'b1, 16'(i));
         chk("t1_done", 64'(bus.acc_done), 64'(i % 4 == 1));
         chk("t1_win_cnt", 64'(bus.win_cnt), 64'((i - 1) % 4 + 1));
      end
      idle(4);
      chk("t1_count", 64'(q.size()), 2);
      chk("t1_sum0", 64'(q[0]), 10);
      chk("t1_sum1", 64'(q[1]), 26);
      step(1'b1, 16'd13);
      idle(4);
      chk("t1_count13", 64'(q.size()), 3);
      chk("t1_sum2", 64'(q[2]), 42);
      chk("t1_overflow", 64'(bus.overflow), 0);

      // len 1: every sample is its own window
      do_reset();
      bus.acc_len = 16'd1;
      step(1'b1, 16'd7);
      step(1'b1, 16'd8);
      step(1'b1, 16'd9);
      step(1'b1, 16'd10);
      idle(4);
      chk("t2_count", 64'(q.size()), 3);
      chk("t2_sum0", 64'(q[0]), 7);
      chk("t2_sum1", 64'(q[1]), 8);
      chk("t2_sum2", 64'(q[2]), 9);
      chk("t2_overflow", 64'(bus.overflow), 0);

      // len 2 with a stalled consumer: FIFO fills, later sums dropped
      do_reset();
      bus.acc_len    = 16'd2;
      bus.dout_ready = 1'b0;
      for (int i = 1; i <= 10; i++) step(1'b1, 16'(i));
      idle(3);
      chk("t3_valid", 64'(bus.dout_valid), 1);
      chk("t3_head", 64'(bus.dout), 3);
      chk("t3_overflow", 64'(bus.overflow), 1);
      idle(1);
      chk("t3_head_stable", 64'(bus.dout), 3);
      chk("t3_none_popped", 64'(q.size()), 0);
      bus.dout_ready = 1'b1;
      idle(4);
      chk("t3_count", 64'(q.size()), 2);
      chk("t3_sum0", 64'(q[0]), 3);
      chk("t3_sum1", 64'(q[1]), 7);
      chk("t3_empty", 64'(bus.dout_valid), 0);
      chk("t3_overflow_sticky", 64'(bus.overflow), 1);

      // len 3, one valid sample every third cycle
      do_reset();
      bus.acc_len = 16'd3;
      for (int k = 1; k <= 10; k++) begin
         step(1'b1, 16'd5);
         chk("t4_win_cnt", 64'(bus.win_cnt), 64'((k - 1) % 3 + 1));
         idle(2);
         chk("t4_win_cnt_hold", 64'(bus.win_cnt), 64'((k - 1) % 3 + 1));
         chk("t4_done_low_idle", 64'(bus.acc_done), 0);
      end
      idle(3);
      chk("t4_count", 64'(q.size()), 3);
      chk("t4_sum0", 64'(q[0]), 15);
      chk("t4_sum1", 64'(q[1]), 15);
      chk("t4_sum2", 64'(q[2]), 15);

      // acc_len changed mid-window takes effect at the next window
      do_reset();
      bus.acc_len = 16'd4;
      step(1'b1, 16'd1);
      step(1'b1, 16'd1);
      bus.acc_len = 16'd2;
      repeat (7) step(1'b1, 16'd1);
      idle(4);
      chk("t5_count", 64'(q.size()), 3);
      chk("t5_sum0", 64'(q[0]), 4);
      chk("t5_sum1", 64'(q[1]), 2);
      chk("t5_sum2", 64'(q[2]), 2);

      // acc_len 0 behaves as 1
      do_reset();
      bus.acc_len = 16'd0;
      step(1'b1, 16'd3);
      step(1'b1, 16'd4);
      step(1'b1, 16'd5);
      idle(4);
      chk("t5z_count", 64'(q.size()), 2);
      chk("t5z_sum0", 64'(q[0]), 3);
      chk("t5z_sum1", 64'(q[1]), 4);

      // reset in the middle of a window
      do_reset();
      bus.acc_len = 16'd4;
      repeat (3) step(1'b1, 16'd1);
      rst = 1'b1;
      step(1'b0, 16'd0);
      chk_reset("t6_rst");
      rst = 1'b0;
      q.delete();
      repeat (5) step(1'b1, 16'd1);
      idle(4);
      chk("t6_count", 64'(q.size()), 1);
      chk("t6_sum0", 64'(q[0]), 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
